fabric_slave_bridge: RTL and testbench

Bridges one slave port of the shared-memory interconnect to a user-fabric register/memory target using a valid/ready request channel and a separate response channel. Accepts one transfer at a time, holds it until the fabric takes it, and returns exactly one `rvalid` per accepted transfer. A timeout guarantees the interconnect never hangs on an unresponsive fabric. One instance sits directly downstream of each interconnect slave port.

---
 rtl/fabric_bridge_pkg.sv | 13 +
 rtl/fabric_slave_bridge.sv | 158 +++++++++++++++
 tb/tb_fabric_slave_bridge.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/fabric_bridge_pkg.sv
// Shared types and constants for the interconnect-to-fabric slave bridge.
package fabric_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } fsb_state_e;

  localparam logic [31:0] FSB_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/fabric_slave_bridge.sv
// Single-outstanding bridge from an interconnect slave port to a valid/ready fabric
// target, with a timeout that answers ERR_DATA when the fabric stops responding.
module fabric_slave_bridge
  import fabric_bridge_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 10,
  parameter int unsigned           TIMEOUT    = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA   = DATA_WIDTH'(FSB_ERR_DATA)
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    data_req_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,

  output logic                    fab_valid_o,
  input  logic                    fab_ready_i,
  output logic [ADDR_WIDTH-1:0]   fab_addr_o,
  output logic                    fab_we_o,
  output logic [DATA_WIDTH/8-1:0] fab_be_o,
  output logic [DATA_WIDTH-1:0]   fab_wdata_o,
  input  logic                    fab_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   fab_rdata_i,

  output logic                    err_o,
  input  logic                    err_clr_i
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  fsb_state_e state, state_next;

  logic [CNT_W-1:0]      cnt, cnt_d;
  logic                  cnt_hit;
  logic                  accept;
  logic                  expire;

  logic                  gnt_d, rvalid_d, fab_valid_d, err_d, we_d;
  logic [DATA_WIDTH-1:0] rdata_d, wdata_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [BE_W-1:0]       be_d;

  // >= rather than == so a read whose ready lands on the expiry cycle still times out in WAIT.
  assign cnt_hit = (cnt >= CNT_W'(TIMEOUT - 1));
  assign accept  = (state == IDLE) && data_req_i;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a handshake in the expiry cycle takes priority over the timeout
  always_comb begin
    state_next = state;
    expire     = 1'b0;
    case (state)
      IDLE: begin
        if (data_req_i) state_next = REQ;
      end
      REQ: begin
        if (fab_ready_i) begin
          state_next = fab_we_o ? RESP : WAIT;
        end else if (cnt_hit) begin
          state_next = RESP;
          expire     = 1'b1;
        end
      end
      WAIT: begin
        if (fab_rvalid_i) begin
          state_next = RESP;
        end else if (cnt_hit) begin
          state_next = RESP;
          expire     = 1'b1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output, latch and counter next values, all registered below
  always_comb begin
    gnt_d       = (state_next == IDLE);
    fab_valid_d = (state_next == REQ);
    rvalid_d    = (state_next == RESP);

    rdata_d = '0;
    if ((state == WAIT) && fab_rvalid_i) begin
      rdata_d = fab_rdata_i;
    end else if (expire) begin
      rdata_d = ERR_DATA;
    end

    err_d = expire | (err_o & ~err_clr_i);

    addr_d  = fab_addr_o;
    we_d    = fab_we_o;
    be_d    = fab_be_o;
    wdata_d = fab_wdata_o;
    if (accept) begin
      addr_d  = data_addr_i;
      we_d    = data_we_i;
      be_d    = data_be_i;
      wdata_d = data_wdata_i;
    end

    cnt_d = cnt;
    if (accept) begin
      cnt_d = '0;
    end else if (((state == REQ) || (state == WAIT)) && (cnt != '1)) begin
      cnt_d = cnt + CNT_W'(1);
    end
  end

  // Registered outputs, request latch and timeout counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_gnt_o    <= 1'b1;
      data_rvalid_o <= 1'b0;
      data_rdata_o  <= '0;
      fab_valid_o   <= 1'b0;
      fab_addr_o    <= '0;
      fab_we_o      <= 1'b0;
      fab_be_o      <= '0;
      fab_wdata_o   <= '0;
      err_o         <= 1'b0;
      cnt           <= '0;
    end else begin
      data_gnt_o    <= gnt_d;
      data_rvalid_o <= rvalid_d;
      data_rdata_o  <= rdata_d;
      fab_valid_o   <= fab_valid_d;
      fab_addr_o    <= addr_d;
      fab_we_o      <= we_d;
      fab_be_o      <= be_d;
      fab_wdata_o   <= wdata_d;
      err_o         <= err_d;
      cnt           <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fabric_slave_bridge.sv
// Directed table-driven bench for fabric_slave_bridge with TIMEOUT=8.
module tb_fabric_slave_bridge;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 10;
  localparam int unsigned TO = 8;
  localparam int unsigned NV = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          data_req_i;
  logic [AW-1:0] data_addr_i;
  logic          data_we_i;
  logic [DW/8-1:0] data_be_i;
  logic [DW-1:0] data_wdata_i;
  logic          data_gnt_o;
  logic          data_rvalid_o;
  logic [DW-1:0] data_rdata_o;
  logic          fab_valid_o;
  logic          fab_ready_i;
  logic [AW-1:0] fab_addr_o;
  logic          fab_we_o;
  logic [DW/8-1:0] fab_be_o;
  logic [DW-1:0] fab_wdata_o;
  logic          fab_rvalid_i;
  logic [DW-1:0] fab_rdata_i;
  logic          err_o;
  logic          err_clr_i;

  int checks = 0;
  int errors = 0;
  logic err_exp = 1'b0;

  fabric_slave_bridge #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .TIMEOUT   (TO),
    .ERR_DATA  (32'hDEAD_BEEF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .data_req_i   (data_req_i),
    .data_addr_i  (data_addr_i),
    .data_we_i    (data_we_i),
    .data_be_i    (data_be_i),
    .data_wdata_i (data_wdata_i),
    .data_gnt_o   (data_gnt_o),
    .data_rvalid_o(data_rvalid_o),
    .data_rdata_o (data_rdata_o),
    .fab_valid_o  (fab_valid_o),
    .fab_ready_i  (fab_ready_i),
    .fab_addr_o   (fab_addr_o),
    .fab_we_o     (fab_we_o),
    .fab_be_o     (fab_be_o),
    .fab_wdata_o  (fab_wdata_o),
    .fab_rvalid_i (fab_rvalid_i),
    .fab_rdata_i  (fab_rdata_i),
    .err_o        (err_o),
    .err_clr_i    (err_clr_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            we;
    logic [AW-1:0]   addr;
    logic [DW/8-1:0] be;
    logic [DW-1:0]   wdata;
    int              rdy_dly;   // cycles fab_ready_i is held low after fab_valid_o rises
    int              rv_dly;    // cycles from the ready cycle to fab_rvalid_i (0 = never)
    logic [DW-1:0]   fdata;
    int              clr_t;     // cycle after acceptance to pulse err_clr_i (0 = none)
    int              exp_lat;   // cycles from acceptance to data_rvalid_o
    logic [DW-1:0]   exp_rdata;
    logic            exp_err;
  } vec_t;

  vec_t vecs [NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_xfer(input vec_t v, input int idx);
    int            lat;
    logic [DW-1:0] rd;
    logic          busy_bad;
    logic          fields_bad;
    lat        = 0;
    rd         = '0;
    busy_bad   = 1'b0;
    fields_bad = 1'b0;
    check($sformatf("v%0d gnt_idle", idx), 64'(data_gnt_o), 64'd1);
    data_req_i   = 1'b1;
    data_addr_i  = v.addr;
    data_we_i    = v.we;
    data_be_i    = v.be;
    data_wdata_i = v.wdata;
    step();
    data_req_i   = 1'b0;
    data_addr_i  = ~v.addr;
    data_we_i    = ~v.we;
    data_be_i    = ~v.be;
    data_wdata_i = ~v.wdata;
    for (int t = 1; t <= 30; t++) begin
      if (data_rvalid_o) begin
        lat = t;
        rd  = data_rdata_o;
        break;
      end
      if (data_gnt_o) busy_bad = 1'b1;
      if (t == 1 && !fab_valid_o) fields_bad = 1'b1;
      if (fab_valid_o && (fab_addr_o !== v.addr || fab_we_o !== v.we ||
                          fab_be_o !== v.be || fab_wdata_o !== v.wdata))
        fields_bad = 1'b1;
      fab_ready_i  = (t >= 1 + v.rdy_dly);
      fab_rvalid_i = (v.rv_dly > 0) && (t == 1 + v.rdy_dly + v.rv_dly);
      fab_rdata_i  = fab_rvalid_i ? v.fdata : 32'h5555_AAAA;
      err_clr_i    = (v.clr_t != 0) && (t == v.clr_t);
      step();
    end
    fab_ready_i  = 1'b0;
    fab_rvalid_i = 1'b0;
    err_clr_i    = 1'b0;
    check($sformatf("v%0d rvalid_latency", idx), 64'(lat), 64'(v.exp_lat));
    check($sformatf("v%0d rdata", idx), 64'(rd), 64'(v.exp_rdata));
    check($sformatf("v%0d fab_fields_stable", idx), 64'(fields_bad), 64'd0);
    check($sformatf("v%0d gnt_low_busy", idx), 64'(busy_bad), 64'd0);
    step();
    check($sformatf("v%0d gnt_back_single_pulse", idx), 64'({data_gnt_o, data_rvalid_o}), 64'b10);
    err_exp = v.exp_err ? 1'b1 : ((v.clr_t != 0) ? 1'b0 : err_exp);
    check($sformatf("v%0d err", idx), 64'(err_o), 64'(err_exp));
  endtask

  initial begin
    int rv_seen;
    //          we    addr     be    wdata          rdy  rv  fdata          clr lat rdata          err
    vecs[0]  = '{1'b1, 10'h012, 4'hF, 32'hA5A5_0001, 0,   0,  32'h0,         0,  2, 32'h0,         1'b0};
    vecs[1]  = '{1'b1, 10'h3FF, 4'h3, 32'h0000_CAFE, 0,   0,  32'h0,         0,  2, 32'h0,         1'b0};
    vecs[2]  = '{1'b0, 10'h040, 4'hF, 32'h0,         0,   3,  32'h1234_5678, 0,  5, 32'h1234_5678, 1'b0};
    vecs[3]  = '{1'b0, 10'h001, 4'hF, 32'h0,         0,   1,  32'h0BAD_F00D, 0,  3, 32'h0BAD_F00D, 1'b0};
    vecs[4]  = '{1'b1, 10'h155, 4'hC, 32'h5A5A_5A5A, 5,   0,  32'h0,         0,  7, 32'h0,         1'b0};
    vecs[5]  = '{1'b0, 10'h2AA, 4'hF, 32'h0,         2,   2,  32'h8765_4321, 0,  6, 32'h8765_4321, 1'b0};
    vecs[6]  = '{1'b0, 10'h0F0, 4'hF, 32'h0,         0,   7,  32'hC0FF_EE00, 0,  9, 32'hC0FF_EE00, 1'b0};
    vecs[7]  = '{1'b1, 10'h00F, 4'h1, 32'h1111_2222, 7,   0,  32'h0,         0,  9, 32'h0,         1'b0};
    vecs[8]  = '{1'b1, 10'h100, 4'hF, 32'h3333_4444, 100, 0,  32'h0,         0,  9, 32'hDEAD_BEEF, 1'b1};
    vecs[9]  = '{1'b0, 10'h200, 4'hF, 32'h0,         1,   100,32'h7777_8888, 0,  9, 32'hDEAD_BEEF, 1'b1};
    vecs[10] = '{1'b1, 10'h0AA, 4'hF, 32'h9999_0000, 0,   0,  32'h0,         1,  2, 32'h0,         1'b0};
    vecs[11] = '{1'b1, 10'h055, 4'hF, 32'hABCD_EF01, 100, 0,  32'h0,         8,  9, 32'hDEAD_BEEF, 1'b1};

    reset        = 1'b1;
    data_req_i   = 1'b0;
    data_addr_i  = '0;
    data_we_i    = 1'b0;
    data_be_i    = '0;
    data_wdata_i = '0;
    fab_ready_i  = 1'b0;
    fab_rvalid_i = 1'b0;
    fab_rdata_i  = '0;
    err_clr_i    = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("reset_ctrl", 64'({data_gnt_o, fab_valid_o, data_rvalid_o, err_o, fab_we_o}), 64'b10000);
    check("reset_fab_fields", 64'({fab_addr_o, fab_be_o, fab_wdata_o}), 64'd0);
    check("reset_rdata", 64'(data_rdata_o), 64'd0);
    step();
    step();
    reset = 1'b1;
    step();

    for (int i = 0; i < int'(NV); i++) begin
      do_xfer(vecs[i], i);
    end

    // err_o stays set without a clear
    step();
    step();
    check("err_sticky", 64'(err_o), 64'd1);

    // Reset while waiting for read data, then a stray fab_rvalid_i
    data_req_i  = 1'b1;
    data_addr_i = 10'h0AB;
    data_we_i   = 1'b0;
    data_be_i   = 4'hF;
    step();
    data_req_i  = 1'b0;
    fab_ready_i = 1'b1;
    step();
    fab_ready_i = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("midreset_ctrl", 64'({data_gnt_o, fab_valid_o, data_rvalid_o, err_o}), 64'b1000);
    check("midreset_fields", 64'({fab_addr_o, fab_be_o}), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    err_exp = 1'b0;
    fab_rvalid_i = 1'b1;
    fab_rdata_i  = 32'hBAAD_BAAD;
    rv_seen = 0;
    step();
    fab_rvalid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (data_rvalid_o) rv_seen++;
      step();
    end
    check("stray_rvalid_ignored", 64'(rv_seen), 64'd0);
    do_xfer(vecs[2], 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
